// File: rtl/operand_fetch.sv
// Operand fetch sequencer: reads a 0/1/2-byte little-endian operand over the 8-bit memory bus.
// Optional OPERAND_FETCH_WAIT_EN adds an RDY input that freezes the fetch while low.
module operand_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
`ifdef OPERAND_FETCH_WAIT_EN
    input  logic                    RDY,
`endif
    input  logic                    START,
    input  logic [1:0]              LEN,
    input  logic [ADDR_WIDTH-1:0]   PC_IN,
    input  logic [DATA_WIDTH-1:0]   DATA_IN,
    output logic [ADDR_WIDTH-1:0]   ADDR,
    output logic                    RD,
    output logic [2*DATA_WIDTH-1:0] OPERAND,
    output logic [ADDR_WIDTH-1:0]   PC_OUT,
    output logic                    DONE,
    output logic                    BUSY,
    output logic [1:0]              state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_LO = 2'd1,
        REQ_HI = 2'd2,
        LAST   = 2'd3
    } state_t;

    // Handshake: START is a request sampled only in IDLE; DONE is a one-cycle
    // valid pulse for OPERAND/PC_OUT with no back-pressure.

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [1:0]              len_q, len_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rd_q, rd_d;
    logic [2*DATA_WIDTH-1:0] operand_q, operand_d;
    logic [ADDR_WIDTH-1:0]   pc_out_q, pc_out_d;
    logic                    done_q, done_d;
    logic                    adv;

`ifdef OPERAND_FETCH_WAIT_EN
    assign adv = RDY;
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            operand_q <= '0;
            pc_out_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            operand_q <= operand_d;
            pc_out_q  <= pc_out_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        addr_d    = addr_q;
        operand_d = operand_q;
        pc_out_d  = pc_out_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    pc_d  = PC_IN;
                    // A length of 3 is clamped to the 2-byte maximum.
                    len_d = (LEN == 2'd3) ? 2'd2 : LEN;
                    if (LEN == 2'd0) begin
                        operand_d = '0;
                        pc_out_d  = PC_IN;
                        done_d    = 1'b1;
                    end else begin
                        addr_d  = PC_IN;
                        state_d = REQ_LO;
                    end
                end
            end
            REQ_LO: begin
                if (adv) begin
                    if (len_q == 2'd2) begin
                        addr_d  = pc_q + ADDR_WIDTH'(1);
                        state_d = REQ_HI;
                    end else begin
                        state_d = LAST;
                    end
                end
            end
            REQ_HI: begin
                if (adv) begin
                    operand_d[DATA_WIDTH-1:0] = DATA_IN;
                    state_d                   = LAST;
                end
            end
            LAST: begin
                if (adv) begin
                    if (len_q == 2'd2) begin
                        operand_d[2*DATA_WIDTH-1:DATA_WIDTH] = DATA_IN;
                    end else begin
                        operand_d = {{DATA_WIDTH{1'b0}}, DATA_IN};
                    end
                    pc_out_d = pc_q + ADDR_WIDTH'(len_q);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        rd_d = (state_d == REQ_LO) || (state_d == REQ_HI);
    end

    assign ADDR    = addr_q;
    assign RD      = rd_q;
    assign OPERAND = operand_q;
    assign PC_OUT  = pc_out_q;
    assign DONE    = done_q;
    assign BUSY    = (state_q != IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a synchronous byte memory model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  len;
  logic [15:0] pc_in;
  logic [7:0]  data_in = 8'h00;
  logic [15:0] addr;
  logic        rd;
  logic [15:0] operand;
  logic [15:0] pc_out;
  logic        done;
  logic        busy;
  logic [1:0]  state_dbg;
  logic        rdy = 1'b1;

  logic [7:0]  mem [0:65535];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .CLK     (clk),
    .RST     (rst),
`ifdef OPERAND_FETCH_WAIT_EN
    .RDY     (rdy),
`endif
    .START   (start),
    .LEN     (len),
    .PC_IN   (pc_in),
    .DATA_IN (data_in),
    .ADDR    (addr),
    .RD      (rd),
    .OPERAND (operand),
    .PC_OUT  (pc_out),
    .DONE    (done),
    .BUSY    (busy),
    .state_o (state_dbg)
  );

  // Synchronous memory: data for an RD cycle appears the following cycle,
  // and is held while the core is not ready.
  always @(posedge clk) begin
    if (rd && rdy) data_in <= mem[addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic launch(input logic [1:0] l, input logic [15:0] pc);
    start = 1'b1;
    len   = l;
    pc_in = pc;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    len   = 2'd0;
    pc_in = 16'h0000;
    mem[16'h1234] = 8'hCD;
    mem[16'h1235] = 8'hAB;
    mem[16'h00FF] = 8'h7E;
    mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22;
    mem[16'h2000] = 8'h5A;
    mem[16'h2001] = 8'hA5;
    mem[16'h3000] = 8'h01;
    mem[16'h3001] = 8'h02;

    // Reset
    tick();
    tick();
    chk("rst_addr", addr, 16'h0000);
    chk("rst_rd", rd, 1'b0);
    chk("rst_operand", operand, 16'h0000);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", state_dbg, 2'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_rd", rd, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end

    // LEN=2 at 0x1234
    launch(2'd2, 16'h1234);
    chk("l2_c1_addr", addr, 16'h1234);
    chk("l2_c1_rd", rd, 1'b1);
    chk("l2_c1_busy", busy, 1'b1);
    tick();
    chk("l2_c2_addr", addr, 16'h1235);
    chk("l2_c2_rd", rd, 1'b1);
    tick();
    chk("l2_c3_rd", rd, 1'b0);
    chk("l2_c3_done", done, 1'b0);
    chk("l2_c3_lo", operand, 16'h00CD);
    tick();
    chk("l2_c4_done", done, 1'b1);
    chk("l2_c4_operand", operand, 16'hABCD);
    chk("l2_c4_pc_out", pc_out, 16'h1236);
    chk("l2_c4_busy", busy, 1'b0);
    tick();
    chk("l2_c5_done", done, 1'b0);
    chk("l2_c5_hold", operand, 16'hABCD);

    // LEN=1 at 0x00FF
    launch(2'd1, 16'h00FF);
    chk("l1_c1_addr", addr, 16'h00FF);
    chk("l1_c1_rd", rd, 1'b1);
    tick();
    chk("l1_c2_rd", rd, 1'b0);
    chk("l1_c2_done", done, 1'b0);
    chk("l1_c2_busy", busy, 1'b1);
    tick();
    chk("l1_c3_done", done, 1'b1);
    chk("l1_c3_operand", operand, 16'h007E);
    chk("l1_c3_pc_out", pc_out, 16'h0100);
    tick();
    chk("l1_c4_done", done, 1'b0);

    // LEN=0 at 0x4000
    launch(2'd0, 16'h4000);
    chk("l0_c1_done", done, 1'b1);
    chk("l0_c1_operand", operand, 16'h0000);
    chk("l0_c1_pc_out", pc_out, 16'h4000);
    chk("l0_c1_rd", rd, 1'b0);
    chk("l0_c1_busy", busy, 1'b0);
    chk("l0_c1_addr_hold", addr, 16'h00FF);
    tick();
    chk("l0_c2_done", done, 1'b0);
    chk("l0_c2_rd", rd, 1'b0);

    // Address wrap
    launch(2'd2, 16'hFFFF);
    chk("wrap_c1_addr", addr, 16'hFFFF);
    tick();
    chk("wrap_c2_addr", addr, 16'h0000);
    chk("wrap_c2_rd", rd, 1'b1);
    tick();
    tick();
    chk("wrap_c4_done", done, 1'b1);
    chk("wrap_c4_operand", operand, 16'h2211);
    chk("wrap_c4_pc_out", pc_out, 16'h0001);

    // LEN=3 behaves as LEN=2
    launch(2'd3, 16'h2000);
    tick();
    chk("l3_c2_addr", addr, 16'h2001);
    tick();
    tick();
    chk("l3_c4_done", done, 1'b1);
    chk("l3_c4_operand", operand, 16'hA55A);
    chk("l3_c4_pc_out", pc_out, 16'h2002);

    // START held through a fetch: ignored while busy, accepted on DONE cycle
    start = 1'b1;
    len   = 2'd2;
    pc_in = 16'h1234;
    tick();
    pc_in = 16'h3000;
    chk("b2b_c1_addr", addr, 16'h1234);
    tick();
    chk("b2b_c2_addr", addr, 16'h1235);
    tick();
    chk("b2b_c3_busy", busy, 1'b1);
    chk("b2b_c3_done", done, 1'b0);
    tick();
    chk("b2b_c4_done", done, 1'b1);
    chk("b2b_c4_operand", operand, 16'hABCD);
    chk("b2b_c4_pc_out", pc_out, 16'h1236);
    tick();
    start = 1'b0;
    chk("b2b_c5_addr", addr, 16'h3000);
    chk("b2b_c5_rd", rd, 1'b1);
    chk("b2b_c5_done", done, 1'b0);
    tick();
    chk("b2b_c6_addr", addr, 16'h3001);
    tick();
    tick();
    chk("b2b_c8_done", done, 1'b1);
    chk("b2b_c8_operand", operand, 16'h0201);
    chk("b2b_c8_pc_out", pc_out, 16'h3002);

    // Reset during REQ_HI aborts the fetch
    launch(2'd2, 16'h1234);
    tick();
    chk("abort_c2_rd", rd, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rd", rd, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_addr", addr, 16'h0000);
    chk("abort_operand", operand, 16'h0000);
    chk("abort_pc_out", pc_out, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", done, 1'b0);
      tick();
    end

`ifdef OPERAND_FETCH_WAIT_EN
    // Three-cycle stall in REQ_HI delays DONE by three cycles
    launch(2'd2, 16'h1234);
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", addr, 16'h1235);
      chk("wait_rd", rd, 1'b1);
      chk("wait_done", done, 1'b0);
    end
    rdy = 1'b1;
    tick();
    chk("wait_c6_rd", rd, 1'b0);
    chk("wait_c6_done", done, 1'b0);
    tick();
    chk("wait_c7_done", done, 1'b1);
    chk("wait_c7_operand", operand, 16'hABCD);
    chk("wait_c7_pc_out", pc_out, 16'h1236);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
